// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix keypad front end. Drives one column at a time,
//            synchronises the row returns, snapshots a full sweep, rejects
//            multi-key (ghost) patterns and debounces press/release over
//            consecutive sweeps. Presents the accepted key as
//            {row one-hot, column one-hot} with a one-cycle strobe.
// Ports    : clk       - system clock
//            nRst      - asynchronous active-low reset
//            row_in    - raw rows, active-high, async (bit3 = row0)
//            col_drive - one-hot column drive (bit3 = col0)
//            cur_key   - [7:4] row one-hot, [3:0] column one-hot, 0 = none
//            strobe    - one-cycle pulse on each newly accepted key
// Options  : KEYPAD_AUTOREPEAT_EN - repeat strobe every REPEAT_SCANS sweeps
//            while a key stays held.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic [7:0] cur_key,
  output logic       strobe
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_TGT  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Synchroniser and scan state
  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [15:0]      snap_q, snap_d;       // col0 rows in [15:12] ... col3 in [3:0]
  logic             sweep_done_q, sweep_done_d;

  // Debounce state
  state_e           state_q, state_d;
  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       cur_key_q, cur_key_d;
  logic             strobe_q, strobe_d;

  // Candidate decode
  logic             found, multi;
  logic [3:0]       hit_idx;
  logic [7:0]       cand_w;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [RPT_W-1:0] RPT_TGT = RPT_W'(REPEAT_SCANS);
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [RPT_W-1:0] rpt_inc;
`else
  // Repeat period has no meaning without auto-repeat; keep it referenced.
  logic unused_repeat_scans;
  assign unused_repeat_scans = (REPEAT_SCANS > 0);
`endif

  assign col_drive = 4'b1000 >> col_idx_q;
  assign cur_key   = cur_key_q;
  assign strobe    = strobe_q;

  // Column timing and snapshot capture. The synced rows at the last divider
  // count reflect row_in from inside the current column's drive window.
  always_comb begin
    div_cnt_d    = div_cnt_q + DIV_W'(1);
    col_idx_d    = col_idx_q;
    snap_d       = snap_q;
    sweep_done_d = 1'b0;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d                          = '0;
      col_idx_d                          = col_idx_q + 2'd1;
      snap_d[{~col_idx_q, 2'b00} +: 4]   = row_s2_q;
      sweep_done_d                       = (col_idx_q == 2'd3);
    end
  end

  // Exactly one set bit in the sweep forms a key; anything else is no key.
  always_comb begin
    found   = 1'b0;
    multi   = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i]) begin
        multi   = multi | found;
        found   = 1'b1;
        hit_idx = 4'(i);
      end
    end
    cand_w = (found && !multi) ?
             {4'b0001 << hit_idx[1:0], 4'b0001 << hit_idx[3:2]} : 8'h00;
  end

  assign cnt_inc = cnt_q + CNT_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
  assign rpt_inc = rpt_cnt_q + RPT_W'(1);
`endif

  // Debounce FSM; advances only on the cycle after a completed sweep.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    cur_key_d = cur_key_q;
    strobe_d  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_cnt_d = (state_q == ST_HELD) ? rpt_cnt_q : '0;
`endif
    if (sweep_done_q) begin
      case (state_q)
        ST_IDLE: begin
          if (cand_w != 8'h00) begin
            cand_d = cand_w;
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_d   = ST_HELD;
              cur_key_d = cand_w;
              strobe_d  = 1'b1;
            end else begin
              state_d = ST_PRESS;
            end
          end
        end
        ST_PRESS: begin
          if (cand_w == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_TGT) begin
              state_d   = ST_HELD;
              cur_key_d = cand_q;
              strobe_d  = 1'b1;
            end
          end else if (cand_w == 8'h00) begin
            state_d = ST_IDLE;
          end else begin
            cand_d = cand_w;
            cnt_d  = CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (cand_w == cur_key_q) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rpt_inc == RPT_TGT) begin
              rpt_cnt_d = '0;
              strobe_d  = 1'b1;
            end else begin
              rpt_cnt_d = rpt_inc;
            end
`else
            // Held key produces no further strobes.
`endif
          end else begin
            cnt_d = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_d   = ST_IDLE;
              cur_key_d = 8'h00;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (cand_w != cur_key_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_TGT) begin
              state_d   = ST_IDLE;
              cur_key_d = 8'h00;
            end
          end else begin
            // Key came back before release was confirmed: no new strobe.
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      row_s1_q     <= '0;
      row_s2_q     <= '0;
      div_cnt_q    <= '0;
      col_idx_q    <= '0;
      snap_q       <= '0;
      sweep_done_q <= 1'b0;
      state_q      <= ST_IDLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      cur_key_q    <= '0;
      strobe_q     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt_q    <= '0;
`endif
    end else begin
      row_s1_q     <= row_in;
      row_s2_q     <= row_s1_q;
      div_cnt_q    <= div_cnt_d;
      col_idx_q    <= col_idx_d;
      snap_q       <= snap_d;
      sweep_done_q <= sweep_done_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      cur_key_q    <= cur_key_d;
      strobe_q     <= strobe_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt_q    <= rpt_cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner (SCAN_DIV=4,
//            DEBOUNCE_SCANS=2). A behavioural keypad matrix drives row_in
//            from col_drive; expected strobes are queued and checked when
//            the DUT strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SWEEP = 16;  // 4 columns x SCAN_DIV

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic [7:0] cur_key;
  logic       strobe;

  logic [15:0] keys = '0;      // bit r*4+c = key at row r, column c pressed
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_key_m;
  logic [7:0]  prev_key = '0;
  int          zero_cycles = 0;

  typedef struct {
    logic [15:0] keys;
    logic [7:0]  exp_key;
    int          n_strobe;
    bit          chk_gap;
  } vec_t;
  vec_t vt[12];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2),
    .REPEAT_SCANS   (64)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .row_in    (row_in),
    .col_drive (col_drive),
    .cur_key   (cur_key),
    .strobe    (strobe)
  );

  // Keypad matrix: a pressed key connects its column drive to its row.
  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col_drive[3-c]) row_in[3-r] = 1'b1;
  end

  // Scoreboard monitor: every strobe must match the next queued key, and a
  // nonzero key may never change directly into another nonzero key.
  always @(negedge clk) begin
    if (nRst) begin
      if (strobe) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL strobe_unexpected: strobe with cur_key=%b, none required", cur_key);
        end else begin
          exp_key_m = exp_q.pop_front();
          if (cur_key !== exp_key_m) begin
            n_fail++;
            $display("FAIL strobe_key: cur_key=%b, required %b", cur_key, exp_key_m);
          end
        end
      end
      if (cur_key != prev_key) begin
        n_cmp++;
        if (prev_key != 8'h00 && cur_key != 8'h00) begin
          n_fail++;
          $display("FAIL zero_gap: cur_key went %b -> %b, required 0 in between", prev_key, cur_key);
        end
      end
      if (cur_key == 8'h00) zero_cycles++;
    end
    prev_key = cur_key;
  end

  function automatic logic [15:0] key(int r, int c);
    key = 16'd1 << (r*4 + c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_queue_empty(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Return at the negedge right after col0 becomes driven again.
  task automatic wait_sweep_start();
    logic seen3;
    seen3 = 1'b0;
    for (int k = 0; k < 4*SWEEP; k++) begin
      @(negedge clk);
      if (col_drive == 4'b0001) seen3 = 1'b1;
      else if (seen3 && col_drive == 4'b1000) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL sweep_start_timeout: col_drive=%b, required 1000 after 0001", col_drive);
  endtask

  initial begin
    logic [3:0] base;
    int         lat;

    vt[0]  = '{key(0,0),             8'b1000_1000, 1, 1'b0};
    vt[1]  = '{16'h0000,             8'b0000_0000, 0, 1'b0};
    vt[2]  = '{key(1,1) | key(2,2),  8'b0000_0000, 0, 1'b0};
    vt[3]  = '{key(1,1),             8'b0100_0100, 1, 1'b0};
    vt[4]  = '{16'h0000,             8'b0000_0000, 0, 1'b0};
    vt[5]  = '{key(2,0),             8'b0010_1000, 1, 1'b0};
    vt[6]  = '{key(2,2),             8'b0010_0010, 1, 1'b1};
    vt[7]  = '{16'h0000,             8'b0000_0000, 0, 1'b0};
    vt[8]  = '{key(0,1) | key(1,1),  8'b0000_0000, 0, 1'b0};
    vt[9]  = '{key(3,1),             8'b0001_0100, 1, 1'b0};
    vt[10] = '{key(0,3),             8'b1000_0001, 1, 1'b1};
    vt[11] = '{16'h0000,             8'b0000_0000, 0, 1'b0};

    // Reset with every row returning high
    keys = 16'hFFFF;
    cycles(3);
    check("reset_col_drive", col_drive, 4'b1000);
    check("reset_cur_key",   cur_key,   8'h00);
    check("reset_strobe",    strobe,    1'b0);

    // Column rotation every SCAN_DIV cycles after reset release
    keys = '0;
    nRst = 1'b1;
    base = 4'b1000;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("col_rotate_%0d", k), col_drive, base >> ((k / 4) % 4));
    end

    // Table-driven presses, releases, ghosts and key changes
    for (int i = 0; i < 12; i++) begin
      keys = vt[i].keys;
      for (int s = 0; s < vt[i].n_strobe; s++) exp_q.push_back(vt[i].exp_key);
      zero_cycles = 0;
      cycles(7*SWEEP);
      check($sformatf("vec%0d_cur_key", i), cur_key, vt[i].exp_key);
      check_queue_empty($sformatf("vec%0d_strobes_pending", i));
      if (vt[i].chk_gap) check($sformatf("vec%0d_zero_gap_seen", i), zero_cycles > 0, 1'b1);
    end

    // Bounce on R3C0: alternate every sweep, then hold
    for (int b = 0; b < 4; b++) begin
      wait_sweep_start();
      keys = (b % 2 == 0) ? key(3,0) : 16'h0000;
    end
    wait_sweep_start();
    check("bounce_no_key", cur_key, 8'h00);
    keys = key(3,0);
    exp_q.push_back(8'b0001_1000);
    cycles(7*SWEEP);
    check("bounce_cur_key", cur_key, 8'b0001_1000);
    check_queue_empty("bounce_strobes_pending");
    keys = '0;
    cycles(7*SWEEP);
    check("bounce_release", cur_key, 8'h00);

    // Reset while in PRESS: full debounce needed afterwards
    wait_sweep_start();
    keys = key(1,2);
    cycles(18);
    nRst = 1'b0;
    #1;
    check("midrst_col_drive", col_drive, 4'b1000);
    check("midrst_cur_key",   cur_key,   8'h00);
    check("midrst_strobe",    strobe,    1'b0);
    cycles(2);
    nRst = 1'b1;
    exp_q.push_back(8'b0100_0010);
    lat = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (strobe) begin
        lat = k;
        break;
      end
    end
    check("midrst_strobe_seen",     lat != 0, 1'b1);
    check("midrst_latency_min",     lat >= 2*SWEEP, 1'b1);
    check("midrst_latency_max",     lat <= 3*SWEEP + 3, 1'b1);
    cycles(2);
    check("midrst_cur_key_after",   cur_key, 8'b0100_0010);
    check_queue_empty("midrst_strobes_pending");
    keys = '0;
    cycles(7*SWEEP);
    check("midrst_release", cur_key, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
